// File: rtl/prng_mixer_core.sv
// Mixed multi-channel PRNG (Galois LFSR / Rule-30 CA lanes) with warmup FSM and output FIFO.
// Optional stuck-output health monitor enabled by defining PRNG_MIXER_HEALTH_EN.

module prng_mixer_lane #(
    parameter int          N            = 32,
    parameter int          IDX          = 0,
    parameter logic [63:0] TAPS         = 64'h80200003,
    parameter logic [63:0] DEFAULT_SEED = 64'hACE1ACE1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] seed,
    input  logic         adv,
    output logic [N-1:0] val
);
    localparam logic [N-1:0] INIT = DEFAULT_SEED[N-1:0] ^ N'(IDX);

    logic [N-1:0] val_q, val_d, step;

    if ((IDX % 2) == 0) begin : g_lfsr
        always_comb step = {1'b0, val_q[N-1:1]} ^ (val_q[0] ? TAPS[N-1:0] : '0);
    end else begin : g_ca
        always_comb begin
            step = '0;
            for (int j = 0; j < N; j++)
                step[j] = val_q[(j + N - 1) % N] ^ (val_q[j] | val_q[(j + 1) % N]);
        end
    end

    // A zero seed would lock both generator kinds, so it is swapped for the lane default.
    always_comb begin
        val_d = val_q;
        if (load)     val_d = (seed == '0) ? INIT : seed;
        else if (adv) val_d = step;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) val_q <= INIT;
        else     val_q <= val_d;
    end

    assign val = val_q;
endmodule

module prng_mixer_core #(
    parameter int          N             = 32,
    parameter int          NUM_SRC       = 4,
    parameter int          WARMUP_CYCLES = 16,
    parameter int          DEPTH         = 4,
    parameter logic [63:0] TAPS          = 64'h80200003,
    parameter logic [63:0] DEFAULT_SEED  = 64'hACE1ACE1,
    localparam int         IW            = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          seed_valid,
    output logic          seed_ready,
    input  logic [IW-1:0] seed_idx,
    input  logic [N-1:0]  seed_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          busy,
    output logic          health_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN} state_t;

    state_t                    state_q, state_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [AW:0]               wr_q, wr_d, rd_q, rd_d;
    logic                      busy_q, busy_d;
    logic [N-1:0]              mem [DEPTH];
    logic [NUM_SRC-1:0][N-1:0] val;
    logic [N-1:0]              mixed;
    logic                      seed_acc, pop, push, adv, flush, full, empty;

    assign seed_ready = (state_q != S_WARMUP) && !stop;
    assign seed_acc   = seed_valid && seed_ready;
    assign empty      = (wr_q == rd_q);
    assign full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign out_valid  = !empty;
    assign pop        = out_valid && out_ready;
    assign push       = (state_q == S_RUN) && !stop && !seed_acc && (!full || pop);
    assign adv        = push || ((state_q == S_WARMUP) && !stop);
    assign flush      = stop || (seed_acc && (state_q == S_RUN));
    assign out_data   = empty ? '0 : mem[rd_q[AW-1:0]];
    assign busy       = busy_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
        prng_mixer_lane #(
            .N(N), .IDX(i), .TAPS(TAPS), .DEFAULT_SEED(DEFAULT_SEED)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .load (seed_acc && (seed_idx == IW'(i))),
            .seed (seed_data),
            .adv  (adv),
            .val  (val[i])
        );
    end

    always_comb begin
        mixed = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (((3 * i) % N) == 0) mixed = mixed ^ val[i];
            else mixed = mixed ^ ((val[i] << ((3 * i) % N)) | (val[i] >> (N - ((3 * i) % N))));
        end
    end

    // The counter holds one extra cycle at zero, so the first push lands WARMUP_CYCLES+2 edges after start.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    state_d = S_WARMUP;
                    cnt_d   = 8'(WARMUP_CYCLES);
                end
                S_WARMUP: begin
                    if (cnt_q == 8'd0) state_d = S_RUN;
                    else               cnt_d   = cnt_q - 8'd1;
                end
                S_RUN: if (seed_acc) begin
                    state_d = S_WARMUP;
                    cnt_d   = 8'(WARMUP_CYCLES);
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d != S_IDLE);
        wr_d   = flush ? '0 : wr_q + (push ? (AW+1)'(1) : '0);
        rd_d   = flush ? '0 : rd_q + (pop  ? (AW+1)'(1) : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_q[AW-1:0]] <= mixed;
    end

`ifdef PRNG_MIXER_HEALTH_EN
    logic [N-1:0] last_q, last_d;
    logic [2:0]   same_q, same_d;
    logic         have_q, have_d, err_q, err_d;

    // same_q counts repeats of last_q; seven repeats means eight identical pushes.
    always_comb begin
        last_d = last_q;
        same_d = same_q;
        have_d = have_q;
        err_d  = err_q;
        if (stop) begin
            same_d = '0;
            have_d = 1'b0;
            err_d  = 1'b0;
        end else if (push) begin
            last_d = mixed;
            have_d = 1'b1;
            if (have_q && (mixed == last_q)) begin
                if (same_q != 3'd7) same_d = same_q + 3'd1;
                if (same_q >= 3'd6) err_d = 1'b1;
            end else begin
                same_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= '0;
            same_q <= '0;
            have_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            same_q <= same_d;
            have_q <= have_d;
            err_q  <= err_d;
        end
    end

    assign health_err = err_q;
`else
    assign health_err = 1'b0;
`endif
endmodule

// File: tb/tb_prng_mixer_core.sv
// Self-checking bench for prng_mixer_core: table-driven seed vectors, randomized
// backpressure against an arithmetic reference model, and hand-written corner sequences.

module tb_prng_mixer_core;
    localparam int          N     = 32;
    localparam int          NS    = 2;
    localparam int          W     = 4;
    localparam int          D     = 4;
    localparam logic [31:0] TAPS  = 32'h80200003;
    localparam logic [31:0] DSEED = 32'hACE1ACE1;

    logic        clk, rst, start, stop, seed_valid, seed_ready, out_valid, out_ready, busy, health_err;
    logic [0:0]  seed_idx;
    logic [31:0] seed_data, out_data;

    prng_mixer_core #(
        .N(N), .NUM_SRC(NS), .WARMUP_CYCLES(W), .DEPTH(D),
        .TAPS(64'h80200003), .DEFAULT_SEED(64'hACE1ACE1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .seed_valid(seed_valid), .seed_ready(seed_ready), .seed_idx(seed_idx), .seed_data(seed_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .health_err(health_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_ch [NS];

    function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
        if (s == 0) return v;
        return (v << s) | (v >> (32 - s));
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : 32'h0);
    endfunction

    function automatic logic [31:0] rule30(input logic [31:0] v);
        logic [31:0] r = '0;
        for (int j = 0; j < 32; j++) r[j] = v[(j + 31) % 32] ^ (v[j] | v[(j + 1) % 32]);
        return r;
    endfunction

    function automatic logic [31:0] mix2(input logic [31:0] a, input logic [31:0] b);
        return rotl(a, 0) ^ rotl(b, 3);
    endfunction

    function automatic logic [31:0] subst(input logic [31:0] s, input int i);
        return (s == 0) ? (DSEED ^ 32'(i)) : s;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] s0, input logic [31:0] s1, input int k);
        logic [31:0] a = subst(s0, 0);
        logic [31:0] b = subst(s1, 1);
        for (int n = 0; n < W + 1 + k; n++) begin
            a = lfsr_step(a);
            b = rule30(b);
        end
        return mix2(a, b);
    endfunction

    task automatic model_adv();
        m_ch[0] = lfsr_step(m_ch[0]);
        m_ch[1] = rule30(m_ch[1]);
    endtask

    task automatic model_next(output logic [31:0] w);
        w = mix2(m_ch[0], m_ch[1]);
        model_adv();
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_ch[i] = DSEED ^ 32'(i);
    endtask

    task automatic model_warm();
        repeat (W + 1) model_adv();
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; seed_valid = 1'b0; out_ready = 1'b0;
        seed_idx = '0; seed_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic seed_write(input int idx, input logic [31:0] v);
        seed_valid = 1'b1; seed_idx = 1'(idx); seed_data = v;
        chk("seed_ready_idle", seed_ready, 1'b1);
        edge1();
        seed_valid = 1'b0;
        m_ch[idx] = subst(v, idx);
    endtask

    task automatic do_start();
        start = 1'b1;
        edge1();
        start = 1'b0;
        model_warm();
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 60) begin
            edge1();
            n++;
        end
        if (!out_valid) chk("wait_valid_timeout", 1'b0, 1'b1);
    endtask

    // Pops the head at the next edge if rdy, comparing it with the model stream.
    task automatic consume(input bit rdy, input string nm);
        logic [31:0] w;
        out_ready = rdy;
        if (out_valid && rdy) begin
            model_next(w);
            chk(nm, out_data, w);
            if (out_data == 32'h0) chk("word_nonzero", out_data, 32'h1);
        end
        edge1();
    endtask

    typedef struct {
        logic [31:0]      s0;
        logic [31:0]      s1;
        logic [2:0][31:0] exp;
    } vec_t;

    vec_t vt [4];

    initial begin
        int n;
        logic [31:0] w;

        vt[0].s0 = 32'h00000000; vt[0].s1 = 32'h00000000;
        vt[1].s0 = 32'h12345678; vt[1].s1 = 32'h9ABCDEF0;
        vt[2].s0 = 32'hFFFFFFFF; vt[2].s1 = 32'h00000001;
        vt[3].s0 = 32'h00000001; vt[3].s1 = 32'h00000000;
        foreach (vt[v]) for (int k = 0; k < 3; k++) vt[v].exp[k] = ref_word(vt[v].s0, vt[v].s1, k);

        // Reset state
        do_reset();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_health", health_err, 1'b0);
        chk("rst_seed_ready", seed_ready, 1'b1);

        // Start latency and steady stream, with a start pulse while busy that must be ignored
        out_ready = 1'b1;
        do_start();
        chk("start_busy", busy, 1'b1);
        chk("warmup_seed_ready", seed_ready, 1'b0);
        wait_valid(n);
        chk("first_valid_edge", n, W + 2);
        for (int i = 0; i < 6; i++) consume(1'b1, "run_word");
        start = 1'b1;
        consume(1'b1, "run_word_start_busy");
        start = 1'b0;
        for (int i = 0; i < 6; i++) consume(1'b1, "run_word");

        // Backpressure: head must stay on the next model word, then resume without gap
        w = mix2(m_ch[0], m_ch[1]);
        for (int i = 0; i < 10; i++) consume(1'b0, "stall");
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_head", out_data, w);
        for (int i = 0; i < 12; i++) consume(1'b1, "release_word");

        // Reseed channel 1 during RUN
        do_reset();
        out_ready = 1'b1;
        do_start();
        wait_valid(n);
        for (int i = 0; i < 4; i++) consume(1'b1, "pre_seed_word");
        seed_valid = 1'b1; seed_idx = 1'b1; seed_data = 32'h12345678;
        chk("seed_ready_run", seed_ready, 1'b1);
        consume(1'b1, "seed_edge_word");
        seed_valid = 1'b0;
        m_ch[1] = 32'h12345678;
        model_warm();
        chk("reseed_flush", out_valid, 1'b0);
        chk("reseed_busy", busy, 1'b1);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            edge1();
            if (out_valid) break;
            n++;
        end
        chk("reseed_low_cycles", n, W + 1);
        for (int i = 0; i < 10; i++) consume(1'b1, "reseed_word");

        // Seed table: IDLE seeds, start, first three words
        foreach (vt[v]) begin
            do_reset();
            seed_write(0, vt[v].s0);
            seed_write(1, vt[v].s1);
            chk("idle_after_seed", busy, 1'b0);
            do_start();
            out_ready = 1'b1;
            wait_valid(n);
            for (int k = 0; k < 3; k++) begin
                w = out_data;
                chk("table_word", w, vt[v].exp[k]);
                edge1();
            end
        end

        // Randomized seeds and backpressure against the model
        do_reset();
        seed_write(0, $urandom);
        seed_write(1, $urandom);
        do_start();
        for (int i = 0; i < 400; i++) consume($urandom_range(0, 3) != 0, "rand_word");

        // Stop mid-RUN flushes and idles
        stop = 1'b1;
        out_ready = 1'b0;
        edge1();
        stop = 1'b0;
        chk("stop_busy", busy, 1'b0);
        chk("stop_valid", out_valid, 1'b0);
        chk("stop_data", out_data, 32'h0);

        // start and stop together in IDLE
        do_reset();
        start = 1'b1; stop = 1'b1;
        edge1();
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", busy, 1'b0);
        repeat (10) edge1();
        chk("startstop_valid", out_valid, 1'b0);

        // Asynchronous reset mid-RUN
        do_reset();
        out_ready = 1'b0;
        do_start();
        wait_valid(n);
        repeat (3) edge1();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_data", out_data, 32'h0);
        edge1();
        rst = 1'b0;

`ifdef PRNG_MIXER_HEALTH_EN
        do_reset();
        out_ready = 1'b1;
        do_start();
        wait_valid(n);
        force dut.mixed = 32'h5A5A5A5A;
        repeat (4) edge1();
        chk("health_early", health_err, 1'b0);
        repeat (8) edge1();
        release dut.mixed;
        repeat (3) edge1();
        chk("health_set", health_err, 1'b1);
        stop = 1'b1;
        edge1();
        stop = 1'b0;
        chk("health_cleared", health_err, 1'b0);
`else
        chk("health_tied_low", health_err, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
